seven_seg_capture: RTL and testbench



---
 rtl/seven_seg_capture_pkg.sv | 35 +++
 rtl/seven_seg_capture_pattern_decoder.sv | 29 ++
 rtl/seven_seg_capture.sv | 195 +++++++++++++++++++
 tb/tb_seven_seg_capture.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_capture_pkg.sv
// Shared definitions for the 7-segment display capture path:
// segment patterns, digit selects, FSM states and the x10 helper.
package seven_seg_pkg;

    // Active-high pgfedcba patterns with the decimal point off.
    localparam logic [7:0] SEG_0 = 8'h3F;
    localparam logic [7:0] SEG_1 = 8'h06;
    localparam logic [7:0] SEG_2 = 8'h5B;
    localparam logic [7:0] SEG_3 = 8'h4F;
    localparam logic [7:0] SEG_4 = 8'h66;
    localparam logic [7:0] SEG_5 = 8'h6D;
    localparam logic [7:0] SEG_6 = 8'h7D;
    localparam logic [7:0] SEG_7 = 8'h07;
    localparam logic [7:0] SEG_8 = 8'h7F;
    localparam logic [7:0] SEG_9 = 8'h6F;

    localparam int DP_BIT = 7;

    localparam logic [3:0] DIG_THOUSANDS = 4'b1000;
    localparam logic [3:0] DIG_HUNDREDS  = 4'b0100;
    localparam logic [3:0] DIG_TENS      = 4'b0010;
    localparam logic [3:0] DIG_UNITS     = 4'b0001;

    typedef enum logic [1:0] {
        COLLECT,
        CONV,
        OUT
    } state_t;

    // Shift-and-add x10; callers keep the result below 2^14.
    function automatic logic [13:0] times_ten(input logic [13:0] x);
        return (x << 3) + (x << 1);
    endfunction

endpackage

// File: rtl/seven_seg_capture_pattern_decoder.sv
// Maps an active-high gfedcba segment pattern back to its BCD digit;
// match drops low for any pattern that is not one of the ten digits.
module seven_seg_pattern_decoder
    import seven_seg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] value,
    output logic       match
);

    always_comb begin
        value = 4'd0;
        match = 1'b1;
        case ({1'b0, pattern})
            SEG_0:   value = 4'd0;
            SEG_1:   value = 4'd1;
            SEG_2:   value = 4'd2;
            SEG_3:   value = 4'd3;
            SEG_4:   value = 4'd4;
            SEG_5:   value = 4'd5;
            SEG_6:   value = 4'd6;
            SEG_7:   value = 4'd7;
            SEG_8:   value = 4'd8;
            SEG_9:   value = 4'd9;
            default: match = 1'b0;
        endcase
    end

endmodule

// File: rtl/seven_seg_capture.sv
// Receive side of the multiplexed 7-segment bus: waits for each digit to settle,
// decodes it, and turns a complete 4-digit frame into a binary number plus dp map.
module seven_seg_capture
    import seven_seg_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter int TIMEOUT_W      = 21
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  digit_in,
    input  logic [7:0]  segments_in,
    output logic [13:0] number_out,
    output logic [3:0]  dp_pos,
    output logic        number_valid,
    output logic        decode_error
);

    localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SETTLE_W-1:0]  SETTLE_LAST  = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    logic [3:0] dig_meta, dig_s, dig_prev;
    logic [7:0] seg_meta, seg_s, seg_prev;
    logic [SETTLE_W-1:0]  settle_cnt;
    logic [TIMEOUT_W-1:0] idle_cnt;
    logic       captured;
    logic       sel_valid;
    logic [1:0] sel_idx;
    logic       dig_changed, changed, settled, capture, timeout;
    logic [3:0] dec_value;
    logic       dec_match;
    logic [3:0] slot_val [4];
    logic [3:0] slot_dp;
    logic [3:0] seen, seen_next;
    logic       frame_start;
    state_t     state, state_next;
    logic [13:0] acc;
    logic [1:0]  conv_idx;
    logic [3:0]  snap_val [4];
    logic [3:0]  snap_dp;

    // Idle level of the bus is all ones, so the synchroniser resets to that.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dig_meta <= '1;
            dig_s    <= '1;
            dig_prev <= '1;
            seg_meta <= '1;
            seg_s    <= '1;
            seg_prev <= '1;
        end else begin
            dig_meta <= digit_in;
            dig_s    <= dig_meta;
            dig_prev <= dig_s;
            seg_meta <= segments_in;
            seg_s    <= seg_meta;
            seg_prev <= seg_s;
        end
    end

    always_comb begin
        sel_valid = 1'b1;
        sel_idx   = 2'd0;
        case (~dig_s)
            DIG_THOUSANDS: sel_idx = 2'd3;
            DIG_HUNDREDS:  sel_idx = 2'd2;
            DIG_TENS:      sel_idx = 2'd1;
            DIG_UNITS:     sel_idx = 2'd0;
            default:       sel_valid = 1'b0;
        endcase
    end

    assign dig_changed = (dig_s != dig_prev);
    assign changed     = dig_changed || (seg_s != seg_prev);
    assign settled     = (settle_cnt == SETTLE_LAST);
    assign capture     = sel_valid && !changed && settled && !captured;
    assign timeout     = (idle_cnt == TIMEOUT_LAST);

    seven_seg_pattern_decoder u_decoder (
        .pattern (~seg_s[6:0]),
        .value   (dec_value),
        .match   (dec_match)
    );

    // The captured flag survives segment-only changes so a dwell yields one capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle_cnt <= '0;
            captured   <= 1'b0;
            idle_cnt   <= '0;
        end else begin
            if (!sel_valid || changed)
                settle_cnt <= '0;
            else if (!settled)
                settle_cnt <= settle_cnt + 1'b1;

            if (dig_changed)
                captured <= 1'b0;
            else if (capture)
                captured <= 1'b1;

            if (capture || timeout)
                idle_cnt <= '0;
            else
                idle_cnt <= idle_cnt + 1'b1;
        end
    end

    assign frame_start = (state == COLLECT) && (seen == 4'b1111);

    always_comb begin
        seen_next = seen;
        if (frame_start)
            seen_next = '0;
        if (capture) begin
            if (dec_match)
                seen_next[sel_idx] = 1'b1;
            else
                seen_next = '0;
        end else if (timeout) begin
            seen_next = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seen         <= '0;
            slot_val     <= '{default: '0};
            slot_dp      <= '0;
            decode_error <= 1'b0;
        end else begin
            seen         <= seen_next;
            decode_error <= capture && !dec_match;
            if (capture && dec_match) begin
                slot_val[sel_idx] <= dec_value;
                slot_dp[sel_idx]  <= ~seg_s[DP_BIT];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= COLLECT;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            COLLECT: if (seen == 4'b1111) state_next = CONV;
            CONV:    if (conv_idx == 2'd0) state_next = OUT;
            OUT:     state_next = COLLECT;
            default: state_next = COLLECT;
        endcase
    end

    // Conversion walks the snapshot from thousands down to units.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc          <= '0;
            conv_idx     <= '0;
            snap_val     <= '{default: '0};
            snap_dp      <= '0;
            number_out   <= '0;
            dp_pos       <= '0;
            number_valid <= 1'b0;
        end else begin
            number_valid <= 1'b0;
            case (state)
                COLLECT: begin
                    if (frame_start) begin
                        snap_val <= slot_val;
                        snap_dp  <= slot_dp;
                        acc      <= '0;
                        conv_idx <= 2'd3;
                    end
                end
                CONV: begin
                    acc      <= times_ten(acc) + {10'd0, snap_val[conv_idx]};
                    conv_idx <= conv_idx - 2'd1;
                end
                OUT: begin
                    number_out   <= acc;
                    dp_pos       <= snap_dp;
                    number_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seven_seg_capture.sv
// Bench for seven_seg_capture: directed and random display frames checked
// against a capture-event level model of the frame assembly rules.
module tb_seven_seg_capture;

    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 64;
    // Cycles from the first drive of a settled piece to the observed valid pulse:
    // 2 sync + 5 settle samples to the capture edge, then 6 more edges to OUT.
    localparam int VALID_DELAY = 13;
    localparam logic [6:0] SEG_TAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                            7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  digit_in;
    logic [7:0]  segments_in;
    logic [13:0] number_out;
    logic [3:0]  dp_pos;
    logic        number_valid;
    logic        decode_error;

    seven_seg_capture #(
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TIMEOUT),
        .TIMEOUT_W      (21)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .digit_in     (digit_in),
        .segments_in  (segments_in),
        .number_out   (number_out),
        .dp_pos       (dp_pos),
        .number_valid (number_valid),
        .decode_error (decode_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int num;
        int dp;
        int at;
    } frame_t;

    frame_t exp_q[$];
    frame_t obs_q[$];
    int cycle = 0;
    int obs_err = 0;
    int exp_err = 0;
    int checks = 0;
    int passes = 0;
    int fails = 0;
    int checked = 0;

    // Reference model state: slots per digit position and the current dwell piece.
    int         m_slot [4];
    int         m_dp [4];
    logic [3:0] m_seen = 4'b0000;
    logic [3:0] last_dig = 4'hF;
    logic [7:0] last_seg = 8'hFF;
    int         piece_len = 0;
    int         piece_start = 0;
    bit         run_cap = 1'b0;
    bit         have_cap = 1'b0;
    int         last_cap = 0;

    always @(posedge clk) cycle <= cycle + 1;

    always @(negedge clk) begin
        if (number_valid === 1'b1)
            obs_q.push_back('{num: int'(number_out), dp: int'(dp_pos), at: cycle});
        if (decode_error === 1'b1)
            obs_err++;
    end

    task automatic checkValue(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] seg_byte(input int v, input logic dp);
        return ~{dp, SEG_TAB[v]};
    endfunction

    function automatic logic [3:0] sel_of(input int pos);
        logic [3:0] s;
        s = 4'b0001 << pos;
        return ~s;
    endfunction

    task automatic modelCapture(input logic [3:0] dig, input logic [7:0] seg);
        int idx = 0;
        int v = -1;
        for (int b = 0; b < 4; b++)
            if (!dig[b]) idx = b;
        for (int k = 0; k < 10; k++)
            if (SEG_TAB[k] == ~seg[6:0]) v = k;
        if (have_cap && (piece_start - last_cap) > TIMEOUT)
            m_seen = 4'b0000;
        have_cap = 1'b1;
        last_cap = piece_start;
        run_cap  = 1'b1;
        if (v < 0) begin
            exp_err++;
            m_seen = 4'b0000;
        end else begin
            m_slot[idx] = v;
            m_dp[idx]   = seg[7] ? 0 : 1;
            m_seen[idx] = 1'b1;
            if (m_seen == 4'b1111) begin
                exp_q.push_back('{num: m_slot[3] * 1000 + m_slot[2] * 100 + m_slot[1] * 10 + m_slot[0],
                                  dp: m_dp[3] * 8 + m_dp[2] * 4 + m_dp[1] * 2 + m_dp[0],
                                  at: piece_start + VALID_DELAY});
                m_seen = 4'b0000;
            end
        end
    endtask

    task automatic modelReset();
        while (exp_q.size() > checked && exp_q[$].at > cycle)
            void'(exp_q.pop_back());
        m_seen    = 4'b0000;
        last_dig  = 4'hF;
        last_seg  = 8'hFF;
        piece_len = 0;
        run_cap   = 1'b0;
        have_cap  = 1'b0;
    endtask

    // Hold one digit/segment combination for len cycles, driven on falling edges.
    task automatic applyStimulus(input logic [3:0] dig, input logic [7:0] seg, input int len);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            if (i == 0 && (dig !== last_dig || seg !== last_seg)) begin
                if (dig !== last_dig) run_cap = 1'b0;
                piece_len   = 0;
                piece_start = cycle;
            end
            digit_in    = dig;
            segments_in = seg;
            last_dig    = dig;
            last_seg    = seg;
            piece_len++;
            if (piece_len == SETTLE + 1 && $countones(~dig) == 1 && !run_cap)
                modelCapture(dig, seg);
        end
    endtask

    task automatic driveFrame(input int value, input logic [3:0] dp,
                              input int dmin, input int dmax, input int gmax);
        int div [4] = '{1, 10, 100, 1000};
        for (int pos = 3; pos >= 0; pos--) begin
            applyStimulus(sel_of(pos), seg_byte((value / div[pos]) % 10, dp[pos]),
                          int'($urandom_range(dmin, dmax)));
            if (gmax > 0)
                applyStimulus(4'hF, 8'hFF, int'($urandom_range(0, gmax)));
        end
    endtask

    task automatic checkOutput(input string tag);
        repeat (20) @(negedge clk);
        checkValue({tag, " valid pulses"}, obs_q.size(), exp_q.size());
        checkValue({tag, " decode_error pulses"}, obs_err, exp_err);
        while (checked < exp_q.size() && checked < obs_q.size()) begin
            int late;
            checkValue({tag, " number_out"}, obs_q[checked].num, exp_q[checked].num);
            checkValue({tag, " dp_pos"}, obs_q[checked].dp, exp_q[checked].dp);
            late = obs_q[checked].at - exp_q[checked].at;
            checkValue({tag, " valid timing offset"}, (late >= -1 && late <= 1) ? 0 : late, 0);
            checked++;
        end
        checked = (obs_q.size() > exp_q.size()) ? obs_q.size() : exp_q.size();
    endtask

    initial begin
        rst         = 1'b1;
        digit_in    = 4'hF;
        segments_in = 8'hFF;
        repeat (3) @(negedge clk);
        checkValue("reset number_out", int'(number_out), 0);
        checkValue("reset dp_pos", int'(dp_pos), 0);
        checkValue("reset number_valid", int'(number_valid), 0);
        checkValue("reset decode_error", int'(decode_error), 0);
        rst = 1'b0;
        applyStimulus(4'hF, 8'hFF, 5);

        driveFrame(1234, 4'b0010, 32, 32, 0);
        checkOutput("frame 1234");

        driveFrame(0, 4'b0000, 32, 32, 0);
        driveFrame(9999, 4'b0000, 32, 32, 0);
        checkOutput("frames 0000/9999");

        applyStimulus(sel_of(3), seg_byte(5, 1'b0), 32);
        applyStimulus(sel_of(2), ~8'h49, 32);
        applyStimulus(sel_of(1), seg_byte(7, 1'b0), 32);
        applyStimulus(sel_of(0), seg_byte(8, 1'b0), 32);
        driveFrame(5678, 4'b0000, 32, 32, 0);
        applyStimulus(4'hF, 8'hFF, 80);
        checkOutput("bad hundreds");

        applyStimulus(sel_of(3), seg_byte(2, 1'b0), 32);
        applyStimulus(sel_of(2), seg_byte(4, 1'b0), 32);
        applyStimulus(sel_of(1), seg_byte(6, 1'b0), 3);
        applyStimulus(sel_of(0), seg_byte(8, 1'b0), 32);
        applyStimulus(sel_of(1), seg_byte(6, 1'b0), 32);
        applyStimulus(sel_of(3), seg_byte(1, 1'b0), 32);
        applyStimulus(sel_of(2), seg_byte(3, 1'b0), 32);
        applyStimulus(sel_of(1), seg_byte(5, 1'b0), 32);
        applyStimulus(sel_of(0), seg_byte(7, 1'b0), 3);
        applyStimulus(sel_of(0), seg_byte(2, 1'b0), 1);
        applyStimulus(sel_of(0), seg_byte(7, 1'b0), 30);
        checkOutput("short dwell and glitch");

        applyStimulus(sel_of(3), seg_byte(9, 1'b0), 32);
        applyStimulus(sel_of(2), seg_byte(8, 1'b0), 32);
        applyStimulus(4'hF, 8'hFF, 100);
        applyStimulus(4'b0011, seg_byte(3, 1'b0), 100);
        applyStimulus(sel_of(1), seg_byte(7, 1'b0), 32);
        applyStimulus(sel_of(0), seg_byte(6, 1'b0), 32);
        applyStimulus(4'hF, 8'hFF, 80);
        checkOutput("timeout discard");

        for (int f = 0; f < 6; f++)
            driveFrame(int'($urandom_range(0, 9999)), 4'($urandom_range(0, 15)), 8, 24, 3);
        checkOutput("random frames");

        applyStimulus(4'hF, 8'hFF, 80);
        applyStimulus(sel_of(3), seg_byte(4, 1'b0), 32);
        applyStimulus(sel_of(2), seg_byte(3, 1'b0), 32);
        applyStimulus(sel_of(1), seg_byte(2, 1'b0), 32);
        applyStimulus(sel_of(0), seg_byte(1, 1'b0), 10);
        @(negedge clk);
        rst         = 1'b1;
        digit_in    = 4'hF;
        segments_in = 8'hFF;
        modelReset();
        @(negedge clk);
        checkValue("mid-conversion reset number_out", int'(number_out), 0);
        checkValue("mid-conversion reset number_valid", int'(number_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(4'hF, 8'hFF, 10);
        checkOutput("reset during conversion");

        driveFrame(4321, 4'b0000, 32, 32, 0);
        checkOutput("frame 4321 after reset");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
